// File: rtl/d_mem_init_sched.sv
// Port-B scheduler for D_MEM: ring requests always own the port, the INIT_VALUE fill engine uses idle cycles.
// Latency: ring request drives port B combinationally in the same cycle; the fill writes one word per idle cycle.
// Backpressure: none toward the ring; the fill stalls whenever the ring hits D_MEM and counts those stalls.
module d_mem_init_sched #(
  parameter int                              INIT_AW       = 10,
  parameter logic [31:0]                     INIT_VALUE    = 32'h0,
  parameter bit                              INIT_ON_RESET = 1'b1,
  parameter int                              MSB_REGION    = 31,
  parameter int                              LSB_REGION    = 24,
  parameter logic [MSB_REGION-LSB_REGION:0]  D_MEM_REGION  = 8'h10,
  parameter int                              OPC_W         = 2,
  parameter logic [OPC_W-1:0]                OPC_RD        = 2'd1,
  parameter logic [OPC_W-1:0]                OPC_WR        = 2'd2
) (
  input  logic                 QClk,
  input  logic                 RstQnnnH,
  input  logic                 InitStartQnnnH,
  input  logic                 F2C_ReqValidQ503H,
  input  logic [OPC_W-1:0]     F2C_ReqOpcodeQ503H,
  input  logic [31:0]          F2C_ReqAddressQ503H,
  input  logic [31:0]          F2C_ReqDataQ503H,
  output logic [INIT_AW+1:0]   MemB_AddressQ503H,
  output logic [3:0]           MemB_ByteEnQ503H,
  output logic [31:0]          MemB_WrDataQ503H,
  output logic                 MemB_RdEnQ503H,
  output logic                 MemB_WrEnQ503H,
  output logic                 InitBusyQnnnH,
  output logic                 InitDoneQnnnH,
  output logic [15:0]          InitStallCntQnnnH,
  output logic                 F2C_WrDuringInitQnnnH
);

  typedef enum logic [1:0] {IDLE, FILL, DONE} t_state;

  t_state              state, stateNxt;
  logic [INIT_AW-1:0]  fillPtr, fillPtrNxt;
  logic                initDone, initDoneNxt;
  logic [15:0]         stallCnt, stallCntNxt;
  logic                wrDuringInit, wrDuringInitNxt;
  logic                ringRd, ringWr, ringHit;
  logic                unusedAddrBits;

  assign ringRd  = (F2C_ReqOpcodeQ503H == OPC_RD);
  assign ringWr  = (F2C_ReqOpcodeQ503H == OPC_WR);
  assign ringHit = F2C_ReqValidQ503H &&
                   (F2C_ReqAddressQ503H[MSB_REGION:LSB_REGION] == D_MEM_REGION) &&
                   (ringRd || ringWr);

  // Address bits between the word offset and the region field do not select anything in D_MEM.
  assign unusedAddrBits = ^F2C_ReqAddressQ503H[LSB_REGION-1:INIT_AW+2];

  always_ff @(posedge QClk or posedge RstQnnnH) begin
    if (RstQnnnH) begin
      state        <= INIT_ON_RESET ? FILL : IDLE;
      fillPtr      <= '0;
      initDone     <= 1'b0;
      stallCnt     <= '0;
      wrDuringInit <= 1'b0;
    end else begin
      state        <= stateNxt;
      fillPtr      <= fillPtrNxt;
      initDone     <= initDoneNxt;
      stallCnt     <= stallCntNxt;
      wrDuringInit <= wrDuringInitNxt;
    end
  end

  always_comb begin
    stateNxt          = state;
    fillPtrNxt        = fillPtr;
    initDoneNxt       = initDone;
    stallCntNxt       = stallCnt;
    wrDuringInitNxt   = wrDuringInit;
    MemB_AddressQ503H = '0;
    MemB_ByteEnQ503H  = '0;
    MemB_WrDataQ503H  = '0;
    MemB_RdEnQ503H    = 1'b0;
    MemB_WrEnQ503H    = 1'b0;

    if (ringHit) begin
      MemB_AddressQ503H = F2C_ReqAddressQ503H[INIT_AW+1:0];
      MemB_ByteEnQ503H  = 4'b1111;
      MemB_WrDataQ503H  = F2C_ReqDataQ503H;
      MemB_RdEnQ503H    = ringRd;
      MemB_WrEnQ503H    = ringWr;
    end

    case (state)
      FILL: begin
        if (ringHit) begin
          if (stallCnt != 16'hFFFF) stallCntNxt = stallCnt + 16'd1;
          // A ring write landing before the fill reaches that word gets overwritten.
          if (ringWr) wrDuringInitNxt = 1'b1;
        end else begin
          MemB_AddressQ503H = {fillPtr, 2'b00};
          MemB_ByteEnQ503H  = 4'b1111;
          MemB_WrDataQ503H  = INIT_VALUE;
          MemB_WrEnQ503H    = 1'b1;
          fillPtrNxt        = fillPtr + INIT_AW'(1);
          if (fillPtr == '1) begin
            stateNxt    = DONE;
            initDoneNxt = 1'b1;
          end
        end
      end
      default: begin
        if (InitStartQnnnH) begin
          stateNxt        = FILL;
          fillPtrNxt      = '0;
          initDoneNxt     = 1'b0;
          stallCntNxt     = '0;
          wrDuringInitNxt = 1'b0;
        end
      end
    endcase

    if (RstQnnnH) begin
      MemB_RdEnQ503H = 1'b0;
      MemB_WrEnQ503H = 1'b0;
    end
  end

  assign InitBusyQnnnH         = (state == FILL);
  assign InitDoneQnnnH         = initDone;
  assign InitStallCntQnnnH     = stallCnt;
  assign F2C_WrDuringInitQnnnH = wrDuringInit;

endmodule

// File: tb/tb_d_mem_init_sched.sv
// Bench for d_mem_init_sched: port-B scoreboard plus a D_MEM model fed by observed writes.
module tb_d_mem_init_sched;
  localparam int          AW = 4;
  localparam logic [31:0] IV = 32'hDEAD_BEEF;
  localparam logic [1:0]  OP_RD = 2'd1;
  localparam logic [1:0]  OP_WR = 2'd2;

  logic QClk = 1'b0;
  always #5 QClk = ~QClk;

  logic        rst, initStart, reqValid;
  logic [1:0]  reqOpcode;
  logic [31:0] reqAddress, reqData;

  logic [AW+1:0] addr;  logic [3:0] be;  logic [31:0] wd;  logic rdEn, wrEn;
  logic busy, done, wrd; logic [15:0] stall;
  logic [AW+1:0] addr2; logic [3:0] be2; logic [31:0] wd2; logic rd2, wr2;
  logic busy2, done2, wrd2; logic [15:0] stall2;

  logic [31:0] memModel [16];
  logic [43:0] sb [$];
  int nVec = 0, nMis = 0, busyTotal = 0, fillMark = 0;

  d_mem_init_sched #(.INIT_AW(AW), .INIT_VALUE(IV), .INIT_ON_RESET(1'b1)) u_dut (
    .QClk(QClk), .RstQnnnH(rst), .InitStartQnnnH(initStart),
    .F2C_ReqValidQ503H(reqValid), .F2C_ReqOpcodeQ503H(reqOpcode),
    .F2C_ReqAddressQ503H(reqAddress), .F2C_ReqDataQ503H(reqData),
    .MemB_AddressQ503H(addr), .MemB_ByteEnQ503H(be), .MemB_WrDataQ503H(wd),
    .MemB_RdEnQ503H(rdEn), .MemB_WrEnQ503H(wrEn),
    .InitBusyQnnnH(busy), .InitDoneQnnnH(done),
    .InitStallCntQnnnH(stall), .F2C_WrDuringInitQnnnH(wrd));

  d_mem_init_sched #(.INIT_AW(AW), .INIT_VALUE(IV), .INIT_ON_RESET(1'b0)) u_noAuto (
    .QClk(QClk), .RstQnnnH(rst), .InitStartQnnnH(1'b0),
    .F2C_ReqValidQ503H(reqValid), .F2C_ReqOpcodeQ503H(reqOpcode),
    .F2C_ReqAddressQ503H(reqAddress), .F2C_ReqDataQ503H(reqData),
    .MemB_AddressQ503H(addr2), .MemB_ByteEnQ503H(be2), .MemB_WrDataQ503H(wd2),
    .MemB_RdEnQ503H(rd2), .MemB_WrEnQ503H(wr2),
    .InitBusyQnnnH(busy2), .InitDoneQnnnH(done2),
    .InitStallCntQnnnH(stall2), .F2C_WrDuringInitQnnnH(wrd2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nVec++;
    if (obs !== exp) begin
      nMis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [43:0] ev(input logic rd, input logic wr, input int word, input logic [31:0] d);
    logic [5:0] a;
    a = 6'(word * 4);
    return {rd, wr, 4'hF, a, d};
  endfunction

  function automatic logic [31:0] dmem(input int word);
    return 32'h1000_0000 + 32'(word * 4);
  endfunction

  // Outputs are sampled at the falling edge; inputs only change 1ns after the rising edge.
  task automatic tick();
    logic [43:0] act, exp;
    @(negedge QClk);
    if (!rst && (rdEn || wrEn)) begin
      act = {rdEn, wrEn, be, addr, wd};
      if (sb.size() == 0) chk("portB_unexpected", act, 44'h0);
      else begin
        exp = sb.pop_front();
        chk("portB", act, exp);
      end
      if (wrEn) memModel[addr[5:2]] = wd;
    end
    if (busy) busyTotal++;
    @(posedge QClk);
    #1;
  endtask

  task automatic ring(input logic v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
    reqValid = v; reqOpcode = op; reqAddress = a; reqData = d;
  endtask

  task automatic pushFill(input int lo, input int hi);
    for (int w = lo; w <= hi; w++) sb.push_back(ev(1'b0, 1'b1, w, IV));
  endtask

  task automatic startFill();
    initStart = 1'b1;
    tick();
    initStart = 1'b0;
    fillMark = busyTotal;
  endtask

  task automatic waitIdle(input string tag, input int expCycles);
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_busyDrop"}, busy, 0);
    chk({tag, "_cycles"}, busyTotal - fillMark, expCycles);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_sbEmpty"}, sb.size(), 0);
  endtask

  task automatic checkIdle2(input string tag);
    chk(tag, {busy2, done2, stall2, wrd2, addr2, be2, wd2, rd2, wr2}, 0);
  endtask

  initial begin
    int bad;
    for (int i = 0; i < 16; i++) memModel[i] = 32'h0;
    rst = 1'b1; initStart = 1'b0;
    ring(1'b0, 2'd0, 32'h0, 32'h0);

    // Reset state, with a ring write held during reset that must not reach port B.
    tick();
    ring(1'b1, OP_WR, dmem(1), 32'h1111_1111);
    #1;
    chk("rst_gate", {rdEn, wrEn}, 0);
    tick();
    chk("rst_busy", busy, 1);
    chk("rst_state", {done, stall, wrd}, 0);
    ring(1'b0, 2'd0, 32'h0, 32'h0);
    #1;
    checkIdle2("noAuto_rst");

    // Fill on reset release, no ring traffic.
    pushFill(0, 15);
    rst = 1'b0;
    fillMark = busyTotal;
    waitIdle("initFill", 16);
    chk("initFill_stall", stall, 0);
    bad = 0;
    for (int i = 0; i < 16; i++) if (memModel[i] !== IV) bad++;
    chk("initFill_memBad", bad, 0);
    checkIdle2("noAuto_afterFill");

    // Ring read of word 5 at fill cycle 3 stalls the fill once.
    pushFill(0, 2);
    sb.push_back(ev(1'b1, 1'b0, 5, 32'h0));
    pushFill(3, 15);
    startFill();
    repeat (3) tick();
    ring(1'b1, OP_RD, dmem(5), 32'h0);
    tick();
    ring(1'b0, 2'd0, 32'h0, 32'h0);
    waitIdle("rdStall", 17);
    chk("rdStall_stall", stall, 1);
    chk("rdStall_wrd", wrd, 0);

    // Ring write to word 12 at fill cycle 2 is flagged and later overwritten.
    pushFill(0, 1);
    sb.push_back(ev(1'b0, 1'b1, 12, 32'h1234_5678));
    pushFill(2, 15);
    startFill();
    chk("wrFill_stallCleared", stall, 0);
    repeat (2) tick();
    ring(1'b1, OP_WR, dmem(12), 32'h1234_5678);
    tick();
    ring(1'b0, 2'd0, 32'h0, 32'h0);
    chk("wrFill_wrd", wrd, 1);
    waitIdle("wrFill", 17);
    chk("wrFill_word12", memModel[12], IV);

    // Write in DONE, then restart with a concurrent ring read which must still be served.
    sb.push_back(ev(1'b0, 1'b1, 3, 32'hA5A5_A5A5));
    ring(1'b1, OP_WR, dmem(3), 32'hA5A5_A5A5);
    tick();
    ring(1'b0, 2'd0, 32'h0, 32'h0);
    chk("done_word3", memModel[3], 32'hA5A5_A5A5);
    chk("done_wrdSticky", wrd, 1);
    sb.push_back(ev(1'b1, 1'b0, 7, 32'h0));
    pushFill(0, 15);
    ring(1'b1, OP_RD, dmem(7), 32'h0);
    initStart = 1'b1;
    tick();
    initStart = 1'b0;
    ring(1'b0, 2'd0, 32'h0, 32'h0);
    fillMark = busyTotal;
    chk("restart_flags", {busy, done, wrd, stall}, {1'b1, 1'b0, 1'b0, 16'h0});
    waitIdle("restart", 16);
    chk("restart_word3", memModel[3], IV);

    // Non-hits (CR region, D_MEM NOP) do not stall; InitStart during FILL is ignored.
    pushFill(0, 15);
    startFill();
    repeat (4) tick();
    ring(1'b1, OP_WR, 32'h0100_0010, 32'hCAFE_0000);
    tick();
    ring(1'b1, 2'd0, dmem(9), 32'hCAFE_0001);
    tick();
    ring(1'b0, 2'd0, 32'h0, 32'h0);
    tick();
    #1;
    checkIdle2("noAuto_midFill");
    tick();
    initStart = 1'b1;
    tick();
    initStart = 1'b0;
    waitIdle("noHit", 16);
    chk("noHit_stall", stall, 0);
    chk("noHit_wrd", wrd, 0);

    // Reset at fill cycle 10 for two cycles: writes gated, fill restarts at word 0.
    pushFill(0, 9);
    startFill();
    repeat (10) tick();
    rst = 1'b1;
    ring(1'b1, OP_WR, dmem(2), 32'h5555_5555);
    #1;
    chk("midRst_gate", {rdEn, wrEn}, 0);
    chk("midRst_state", {busy, done, stall}, {1'b1, 1'b0, 16'h0});
    chk("midRst_sbDrained", sb.size(), 0);
    tick();
    tick();
    ring(1'b0, 2'd0, 32'h0, 32'h0);
    pushFill(0, 15);
    rst = 1'b0;
    fillMark = busyTotal;
    #1;
    chk("midRst_firstAddr", {wrEn, addr}, {1'b1, 6'h00});
    checkIdle2("noAuto_afterRst");
    waitIdle("midRst", 16);
    chk("midRst_wrd", wrd, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end
endmodule
